dma_sync_fifo: RTL

//  - Single-clock data FIFO between master_dma's read FSM (writer) and write FSM (reader).
//  - Decouples AXI read bursts from AXI write handshakes.
//  - Read data is registered: the DMA's one-cycle buffer-wait timing relies on this latency.
//  - Adds occupancy count, almost-full/empty thresholds and a synchronous flush.

---
 rtl/dma_sync_fifo_pkg.sv | 17 +
 rtl/dma_fifo_ram.sv | 24 ++
 rtl/dma_sync_fifo.sv | 119 +++++++++++
 3 files changed

// File: rtl/dma_sync_fifo_pkg.sv
// Shared constants for the DMA data FIFO: default geometry and status-word bit positions.
// Consumers import dma_sync_fifo_pkg::* instead of including a defines header.
package dma_sync_fifo_pkg;

  localparam int DMA_DATA_W     = 32;
  localparam int DMA_FIFO_DEPTH = 16;
  localparam int DMA_WORD_BYTES = 4;

  // Bit positions of FIFO flags inside the status word exported to the DMA debug bus.
  localparam int STAT_EMPTY_BIT        = 0;
  localparam int STAT_FULL_BIT         = 1;
  localparam int STAT_ALMOST_EMPTY_BIT = 2;
  localparam int STAT_ALMOST_FULL_BIT  = 3;
  localparam int STAT_OVERFLOW_BIT     = 4;
  localparam int STAT_UNDERFLOW_BIT    = 5;

endpackage

// File: rtl/dma_fifo_ram.sv
// DEPTH x DATA_W simple dual-port RAM with synchronous write and registered read.
// Storage and the read register are deliberately not reset.
module dma_fifo_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dma_sync_fifo.sv
// Single-clock data FIFO between the DMA read FSM (writer) and write FSM (reader).
// Optional sticky overflow/underflow flags are built only when DMA_FIFO_ERR_FLAGS_EN is defined.
module dma_sync_fifo
  import dma_sync_fifo_pkg::*;
#(
  parameter int DATA_W    = DMA_DATA_W,
  parameter int DEPTH     = DMA_FIFO_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              fifo_wr_en,
  input  logic [DATA_W-1:0] fifo_din,
  input  logic              fifo_rd_en,
  output logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic [ADDR_W:0]   fifo_count,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);

  logic [ADDR_W:0]   wr_ptr, rd_ptr, count_nxt;
  logic              wr_acc, rd_acc;
  logic              dout_zero;
  logic [DATA_W-1:0] ram_q;

  assign wr_acc = fifo_wr_en && !fifo_full;
  assign rd_acc = fifo_rd_en && !fifo_empty;

  dma_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc && !clear),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (fifo_din),
    .rd_en   (rd_acc && !clear),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (ram_q)
  );

  // The RAM read register has no reset, so reset/clear force the visible output to zero
  // until the next accepted read loads a real word.
  assign fifo_dout = dout_zero ? '0 : ram_q;

  always_comb begin
    count_nxt = fifo_count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = fifo_count + 1'b1;
      2'b01:   count_nxt = fifo_count - 1'b1;
      default: count_nxt = fifo_count;
    endcase
  end

  // Flags are derived from the next count so they change on the same edge as the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      fifo_empty   <= 1'b1;
      fifo_full    <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      dout_zero    <= 1'b1;
    end else if (clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      fifo_empty   <= 1'b1;
      fifo_full    <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      dout_zero    <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr    <= rd_ptr + 1'b1;
        dout_zero <= 1'b0;
      end
      fifo_count   <= count_nxt;
      fifo_empty   <= (count_nxt == '0);
      fifo_full    <= (count_nxt == DEPTH_C);
      almost_empty <= (count_nxt <= AE_C);
      almost_full  <= (count_nxt >= AF_C);
    end
  end

`ifdef DMA_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (fifo_wr_en && fifo_full)  overflow  <= 1'b1;
      if (fifo_rd_en && fifo_empty) underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
